main_sdiv_126s_63ns_64_seq: RTL
===============================

// Module: main_sdiv_126s_63ns_64_seq
// PURPOSE
//   Iterative restoring divider: signed dividend / unsigned divisor -> signed quotient + remainder.
//   Inverse companion of the 64s x 63ns pipelined multiplier in the locobot datapath.
//   Used to recover fixed-point values after wide products (126b / 63b -> 64b). One quotient bit per ce-cycle.
//   Start/ready/done handshake; one operation in flight at a time.
// PARAMETERS
//   ID          1    instance tag, no functional effect
//   DIVIDEND_W  126  dividend width, two's complement
//   DIVISOR_W   63   divisor width, unsigned (zero-extended internally)
//   QUOT_W      64   quotient width, two's complement
// PORTS
//   clk           in   1            sole clock, rising edge
//   reset_n       in   1            one clock; reset is asynchronous and active-low
//   ce            in   1            clock enable; low freezes all state except reset
//   start         in   1            request; accepted only when ce=1 and ready=1
//   din0          in   DIVIDEND_W   dividend, sampled on accepted start
//   din1          in   DIVISOR_W    divisor, sampled on accepted start
//   ready         out  1            1 in IDLE
//   done          out  1            result-valid strobe, one ce-cycle wide
//   quot          out  QUOT_W       signed quotient, held until next done
//   rem           out  DIVISOR_W+1  signed remainder, held until next done
//   div_by_zero   out  1            sticky with result: din1 was 0
//   overflow      out  1            sticky with result: true quotient not representable in QUOT_W
// BEHAVIOUR
//   Reset (reset_n=0, async): state=IDLE, counter=0; ready=1; done, quot, rem, div_by_zero, overflow = 0.
//   All non-reset transitions occur only on clk edges with ce=1; with ce=0 the state, counter and outputs hold
//     (a done that is high stays high until the next ce=1 edge).
//   FSM: IDLE -> CALC (start, din1!=0) | FIX (start, din1==0); CALC -> FIX after DIVIDEND_W iterations;
//     FIX -> DONE; DONE -> IDLE. start in any state other than IDLE is ignored (no queueing).
//   Accept edge: latch sign s = din0[MSB], |din0| (DIVIDEND_W+1 bits so -2^(W-1) is exact), din1, zero flag.
//   CALC: per edge, shift partial remainder left 1, bring in next dividend MSB; if >= divisor, subtract and set q bit=1.
//   Arithmetic: truncating division (C semantics): quotient rounds toward zero; rem has sign of dividend;
//     |rem| < din1; identity din0 == quot*din1 + rem whenever overflow=0.
//   FIX: apply sign: quot = s ? -Q : Q (low QUOT_W bits kept, wraps); rem = s ? -R : R.
//     overflow=1 iff Q > 2^(QUOT_W-1)-1 (s=0) or Q > 2^(QUOT_W-1) (s=1).
//   Divide by zero: CALC skipped; quot = {QUOT_W{1'b1}}, rem = 0, div_by_zero=1, overflow=0.
//   Latency (ce=1 edges from accept edge to done=1): DIVIDEND_W+1 normal; 2 for divide by zero.
//   done=1 for exactly the DONE state; ready returns 1 on the following ce-cycle; back-to-back start accepted
//     on the first ready=1 cycle.
//   Reset asserted mid-operation: immediate IDLE, no done, outputs cleared to reset values.
// CONFIGURATION
//   MAIN_SDIV_ABORT_EN defined: extra input port abort (1b, after start). abort=1 with ce=1 in CALC or FIX
//     -> IDLE on that edge; no done; quot/rem/flags keep their previous result. abort in IDLE/DONE is ignored;
//     abort and start in the same IDLE cycle: start wins.
//   Not defined: no abort port; an operation, once accepted, always runs to done.
// TESTING
//   din0=100, din1=7, ce=1 -> done 127 edges after accept; quot=14, rem=2, flags 0.
//   din0=-100, din1=7 -> quot=-14, rem=-2; din0=-2^125, din1=1 -> overflow=1, quot=0 (wrapped low 64b).
//   din0=5, din1=0 -> done 2 edges after accept; quot=all ones, rem=0, div_by_zero=1.
//   din0=100, din1=7, ce held 0 for 10 cycles mid-CALC -> done 137 cycles after accept, result unchanged; start
//     pulsed while busy -> ignored.
//   reset_n=0 at cycle 50 of an operation -> ready=1, done never pulses, all outputs 0; next start runs normally.
//   (MAIN_SDIV_ABORT_EN) 100/7 completed, then 9/3 aborted at CALC cycle 20 -> no done, quot stays 14, ready=1 next cycle.

Source files
------------

// File: rtl/main_sdiv_126s_63ns_64_seq.sv
// main_sdiv_126s_63ns_64_seq: iterative restoring divider.
// Signed DIVIDEND_W-bit dividend / unsigned DIVISOR_W-bit divisor. The result is
// truncating division: a signed QUOT_W-bit quotient plus a signed remainder.
// One quotient bit is produced per ce-cycle, and one operation is in flight at a time.
// Optional build macro MAIN_SDIV_ABORT_EN adds an 'abort' input that cancels a
// running operation and keeps the previous result.
module main_sdiv_126s_63ns_64_seq #(
  parameter int ID         = 1,
  parameter int DIVIDEND_W = 126,
  parameter int DIVISOR_W  = 63,
  parameter int QUOT_W     = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce,
  input  logic                  start,
`ifdef MAIN_SDIV_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  ready,
  output logic                  done,
  output logic [QUOT_W-1:0]     quot,
  output logic [DIVISOR_W:0]    rem,
  output logic                  div_by_zero,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] ITERS = CNT_W'(DIVIDEND_W);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  sign_q, sign_d;
  logic                  zero_q, zero_d;
  logic [DIVIDEND_W-1:0] dq_q, dq_d;    // dividend magnitude shifting out, quotient shifting in
  logic [DIVISOR_W-1:0]  r_q, r_d;      // partial remainder, always < divisor
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [QUOT_W-1:0]     quot_q, quot_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  logic                  dbz_q, dbz_d;
  logic                  ovf_q, ovf_d;

  logic                  abort_req;
`ifdef MAIN_SDIV_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Magnitude of the dividend. DIVIDEND_W unsigned bits hold 2^(W-1) exactly,
  // so the most negative dividend needs no extra bit.
  logic [DIVIDEND_W-1:0] din0_abs;
  assign din0_abs = din0[DIVIDEND_W-1] ? (~din0 + 1'b1) : din0;

  // One restoring step: shift in the next dividend bit, then subtract if the trial fits.
  logic [DIVISOR_W:0]    trial;
  logic                  ge;
  logic [DIVISOR_W-1:0]  r_step;
  logic [DIVIDEND_W-1:0] dq_step;
  assign trial   = {r_q, dq_q[DIVIDEND_W-1]};
  assign ge      = trial >= {1'b0, dvs_q};
  assign r_step  = ge ? (trial[DIVISOR_W-1:0] - dvs_q) : trial[DIVISOR_W-1:0];
  assign dq_step = {dq_q[DIVIDEND_W-2:0], ge};

  // Sign fix-up and range check on the unsigned quotient magnitude.
  logic ovf_pos, ovf_neg;
  assign ovf_pos = |dq_q[DIVIDEND_W-1:QUOT_W-1];
  assign ovf_neg = (|dq_q[DIVIDEND_W-1:QUOT_W]) | (dq_q[QUOT_W-1] & (|dq_q[QUOT_W-2:0]));

  // Next-state, datapath and result update; nothing moves while ce is low.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    dq_d    = dq_q;
    r_d     = r_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    if (ce) begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            sign_d = din0[DIVIDEND_W-1];
            dq_d   = din0_abs;
            dvs_d  = din1;
            r_d    = '0;
            zero_d = (din1 == '0);
            if (din1 == '0) begin
              // Two FIX cycles keep the divide-by-zero latency at a fixed two edges.
              state_d = S_FIX;
              cnt_d   = ONE;
            end else begin
              state_d = S_CALC;
              cnt_d   = ITERS;
            end
          end
        end
        S_CALC: begin
          if (abort_req) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            dq_d  = dq_step;
            r_d   = r_step;
            cnt_d = cnt_q - ONE;
            if (cnt_q == ONE) state_d = S_FIX;
          end
        end
        S_FIX: begin
          if (abort_req) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
          end else begin
            state_d = S_DONE;
            if (zero_q) begin
              quot_d = '1;
              rem_d  = '0;
              dbz_d  = 1'b1;
              ovf_d  = 1'b0;
            end else begin
              quot_d = sign_q ? (~dq_q[QUOT_W-1:0] + 1'b1) : dq_q[QUOT_W-1:0];
              rem_d  = sign_q ? (~{1'b0, r_q} + 1'b1) : {1'b0, r_q};
              dbz_d  = 1'b0;
              ovf_d  = sign_q ? ovf_neg : ovf_pos;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and result registers; reset returns to IDLE with outputs cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      dq_q    <= '0;
      r_q     <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      dq_q    <= dq_d;
      r_q     <= r_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ready       = (state_q == S_IDLE);
  assign done        = (state_q == S_DONE);
  assign quot        = quot_q;
  assign rem         = rem_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

endmodule
